decode_stage: RTL

Parametrised instruction-decode stage with integrated register file and ID/EX pipeline register. The block decodes a 32-bit MIPS-style instruction, reads two source operands with write-back bypass, and extends the immediate (including a `lui` mode). It selects and performs the register write-back, then presents the decoded bundle to the execute stage through a valid/ready handshake with flush. It sits between instruction fetch and the ALU.

---
 rtl/decode_stage_if.sv | 33 +++
 rtl/decode_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Decode-stage handshake bundle: fetch-side instruction input and ID/EX output toward execute.
interface decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_pc_plus4;
    logic              in_jal;
    logic              in_regdst;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [ADDR_W-1:0] out_dest;
    logic [31:0]       out_instr;
    logic [DATA_W-1:0] out_pc_plus4;

    modport master (
        output in_valid, in_instr, in_pc_plus4, in_jal, in_regdst, out_ready, flush,
        input  in_ready, out_valid, out_rs_data, out_rt_data, out_imm, out_dest,
               out_instr, out_pc_plus4
    );

    modport slave (
        input  in_valid, in_instr, in_pc_plus4, in_jal, in_regdst, out_ready, flush,
        output in_ready, out_valid, out_rs_data, out_rt_data, out_imm, out_dest,
               out_instr, out_pc_plus4
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode with register file, write-back bypass and ID/EX register.
// Latency 1 cycle; input stalls while the held bundle is not consumed, flush drops it.
module decode_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_CNT  = 32,
    parameter int LINK_REG = REG_CNT - 1,
    localparam int ADDR_W  = $clog2(REG_CNT)
) (
    input  logic              clock,
    input  logic              reset,
    decode_stage_if.slave     bus,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_jal,
    input  logic              wb_mem_to_reg,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [DATA_W-1:0] wb_pc_plus4,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;

    logic [DATA_W-1:0] wb_data;
    logic              wr_en;
    logic [ADDR_W-1:0] rs_idx, rt_idx;
    logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
    logic [ADDR_W-1:0] dest_sel;
    logic [5:0]        opcode;
    logic              in_ready;
    logic              capture;

    assign wb_data = wb_jal        ? wb_pc_plus4 :
                     wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    // r0 is never written, so it reads zero without a read-side mask
    assign wr_en   = wb_reg_write && (wb_addr != '0);

    assign rs_idx = bus.in_instr[21 +: ADDR_W];
    assign rt_idx = bus.in_instr[16 +: ADDR_W];
    assign rs_val = (wr_en && wb_addr == rs_idx) ? wb_data : regs_q[rs_idx];
    assign rt_val = (wr_en && wb_addr == rt_idx) ? wb_data : regs_q[rt_idx];
    assign opcode = bus.in_instr[31:26];

    always_comb begin
        imm_ext = {DATA_W{bus.in_instr[15]}};
        case (opcode)
            6'd9, 6'd11, 6'd12, 6'd13, 6'd14: begin
                imm_ext        = '0;
                imm_ext[15:0]  = bus.in_instr[15:0];
            end
            // lui: bits above 31 are already filled with instr[15], the new bit 31
            6'd15: imm_ext[31:0] = {bus.in_instr[15:0], 16'h0000};
            default: imm_ext[15:0] = bus.in_instr[15:0];
        endcase
    end

    assign dest_sel = bus.in_jal    ? ADDR_W'(LINK_REG) :
                      bus.in_regdst ? bus.in_instr[11 +: ADDR_W] : rt_idx;

    assign in_ready = !bus.flush && (!valid_q || bus.out_ready);
    assign capture  = bus.in_valid && in_ready;

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        dest_d    = dest_q;
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d   = 1'b1;
            rs_data_d = rs_val;
            rt_data_d = rt_val;
            imm_d     = imm_ext;
            dest_d    = dest_sel;
            instr_d   = bus.in_instr;
            pc4_d     = bus.in_pc_plus4;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
            valid_q   <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            dest_q    <= '0;
            instr_q   <= '0;
            pc4_q     <= '0;
        end else begin
            regs_q    <= regs_d;
            valid_q   <= valid_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            dest_q    <= dest_d;
            instr_q   <= instr_d;
            pc4_q     <= pc4_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = valid_q;
    assign bus.out_rs_data  = rs_data_q;
    assign bus.out_rt_data  = rt_data_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_dest     = dest_q;
    assign bus.out_instr    = instr_q;
    assign bus.out_pc_plus4 = pc4_q;
    assign dbg_data         = regs_q[dbg_addr];
endmodule
